// File: rtl/sram_2p_hs.sv
// Simple-dual-port SRAM with valid/ready write and read channels, selectable
// read-during-write behaviour, optional output register and a credit-managed response queue.
module sram_2p_hs #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4,
    parameter int DEPTH      = 1024,
    parameter int RDW_NEW    = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [MASK_WIDTH-1:0] wr_mask,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);

    localparam int LAT       = (OUT_REG != 0) ? 2 : 1;
    localparam int RSP_DEPTH = LAT + 1;
    localparam int PTR_W     = $clog2(RSP_DEPTH);
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

    localparam logic [PTR_W-1:0]    PTR_LAST    = PTR_W'(RSP_DEPTH - 1);
    localparam logic [PTR_W-1:0]    PTR_ONE     = PTR_W'(1);
    localparam logic [CNT_W-1:0]    CNT_FULL    = CNT_W'(RSP_DEPTH);
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wrFire;
    logic                  wrInRange;
    logic                  rdFire;
    logic                  rdInRange;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] laneBits;
    logic [DATA_WIDTH-1:0] oldWord;
    logic [DATA_WIDTH-1:0] rdWord;
    logic [DATA_WIDTH-1:0] rdResultData;
    logic                  rdResultErr;
    logic [DATA_WIDTH-1:0] pushData;
    logic                  pushErr;

    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      credits_q, credits_d;
    logic [DATA_WIDTH-1:0] qData_q [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]  qErr_q;

    assign wr_ready  = 1'b1;
    assign wrFire    = wr_valid;
    assign wrInRange = {1'b0, wr_addr} < DEPTH_LIMIT;
    assign rdInRange = {1'b0, rd_addr} < DEPTH_LIMIT;
    assign rd_ready  = (credits_q != '0);
    assign rdFire    = rd_valid & rd_ready;

    // Expand byte-lane enables to a per-bit mask; a short final lane absorbs the leftover bits.
    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_laneBits
        localparam int LANE = ((b / 8) < MASK_WIDTH) ? (b / 8) : (MASK_WIDTH - 1);
        assign laneBits[b] = wr_mask[LANE];
    end

    always_ff @(posedge clk) begin
        if (wrFire && wrInRange) begin
            mem[wr_addr] <= (mem[wr_addr] & ~laneBits) | (wr_data & laneBits);
        end
    end

    always_comb begin
        oldWord = mem[rd_addr];
        rdWord  = oldWord;
        if ((RDW_NEW != 0) && wrFire && (wr_addr == rd_addr)) begin
            rdWord = (oldWord & ~laneBits) | (wr_data & laneBits);
        end
        rdResultData = rdInRange ? rdWord : '0;
        rdResultErr  = ~rdInRange;
    end

    if (OUT_REG != 0) begin : g_outReg
        logic                  stgValid_q;
        logic [DATA_WIDTH-1:0] stgData_q;
        logic                  stgErr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stgValid_q <= 1'b0;
                stgData_q  <= '0;
                stgErr_q   <= 1'b0;
            end else begin
                stgValid_q <= rdFire;
                if (rdFire) begin
                    stgData_q <= rdResultData;
                    stgErr_q  <= rdResultErr;
                end
            end
        end

        assign push     = stgValid_q;
        assign pushData = stgData_q;
        assign pushErr  = stgErr_q;
    end else begin : g_noOutReg
        assign push     = rdFire;
        assign pushData = rdResultData;
        assign pushErr  = rdResultErr;
    end

    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_data  = rsp_valid ? qData_q[rdPtr_q] : '0;
    assign rsp_err   = rsp_valid & qErr_q[rdPtr_q];

    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        credits_d = credits_q;
        if (push) begin
            wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + PTR_ONE;
        end
        if (pop) begin
            rdPtr_d = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // A credit covers a read from acceptance until its response is popped.
        case ({rdFire, pop})
            2'b10:   credits_d = credits_q - CNT_ONE;
            2'b01:   credits_d = credits_q + CNT_ONE;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            credits_q <= CNT_FULL;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            credits_q <= credits_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qData_q[wrPtr_q] <= pushData;
            qErr_q[wrPtr_q]  <= pushErr;
        end
    end

    queueNoOverflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == CNT_FULL)));

endmodule

// File: tb/tb_sram_2p_hs.sv
// Directed scoreboard bench for sram_2p_hs, exercising two configurations side by side:
// dut0 (OUT_REG=0, RDW_NEW=0) and dut1 (OUT_REG=1, RDW_NEW=1), both with DEPTH=1000.
module tb_sram_2p_hs;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int DEPTH = 1000;

    logic          clk = 1'b0;
    logic          rstN;
    logic [1:0]    wrValid, rdValid, rspReady;
    logic [1:0]    wrReady, rdReady, rspValid, rspErr;
    logic [AW-1:0] wrAddr, rdAddr;
    logic [DW-1:0] wrData;
    logic [MW-1:0] wrMask;
    logic [DW-1:0] rspData [2];

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            at;
    } rsp_t;

    rsp_t          sb[$];
    int            popLog[$];
    logic [DW-1:0] mdl [2][1024];
    logic [DW-1:0] lastPopData;
    logic          lastPopErr;
    int            mdlCredits;
    int            cyc;
    int            assertCount;
    int            failCount;

    always #5 clk = ~clk;

    sram_2p_hs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .DEPTH(DEPTH),
                 .RDW_NEW(0), .OUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rstN),
        .wr_valid(wrValid[0]), .wr_ready(wrReady[0]), .wr_addr(wrAddr), .wr_data(wrData),
        .wr_mask(wrMask), .rd_valid(rdValid[0]), .rd_ready(rdReady[0]), .rd_addr(rdAddr),
        .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]), .rsp_data(rspData[0]),
        .rsp_err(rspErr[0])
    );

    sram_2p_hs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .DEPTH(DEPTH),
                 .RDW_NEW(1), .OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rstN),
        .wr_valid(wrValid[1]), .wr_ready(wrReady[1]), .wr_addr(wrAddr), .wr_data(wrData),
        .wr_mask(wrMask), .rd_valid(rdValid[1]), .rd_ready(rdReady[1]), .rd_addr(rdAddr),
        .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]), .rsp_data(rspData[1]),
        .rsp_err(rspErr[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int rspDepth(input int d);
        return lat(d) + 1;
    endfunction

    function automatic bit rdwNew(input int d);
        return d != 0;
    endfunction

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Runs at the falling edge: compares outputs with the model, then books whatever the
    // coming rising edge will do (pop, read accept, write) into the model.
    task automatic checkOutput(input int d);
        bit   canAccept;
        bit   expValid;
        rsp_t e;
        canAccept = (mdlCredits != 0);
        expValid  = 1'b0;
        if (sb.size() != 0) expValid = (sb[0].at <= cyc);
        checkEq("rdReady", rdReady[d], canAccept);
        checkEq("rspValid", rspValid[d], expValid);
        if (expValid) begin
            checkEq("rspData", rspData[d], sb[0].data);
            checkEq("rspErr", rspErr[d], sb[0].err);
            if (rspReady[d]) begin
                lastPopData = rspData[d];
                lastPopErr  = rspErr[d];
                void'(sb.pop_front());
                mdlCredits++;
                popLog.push_back(cyc);
            end
        end
        if (rdValid[d] && canAccept) begin
            e.err  = (rdAddr >= DEPTH);
            e.data = '0;
            e.at   = cyc + lat(d);
            if (!e.err) begin
                e.data = mdl[d][rdAddr];
                if (rdwNew(d) && wrValid[d] && (wrAddr == rdAddr)) begin
                    for (int i = 0; i < MW; i++)
                        if (wrMask[i]) e.data[8*i +: 8] = wrData[8*i +: 8];
                end
            end
            sb.push_back(e);
            mdlCredits--;
        end
        if (wrValid[d] && (wrAddr < DEPTH)) begin
            for (int i = 0; i < MW; i++)
                if (wrMask[i]) mdl[d][wrAddr][8*i +: 8] = wrData[8*i +: 8];
        end
    endtask

    task automatic applyStimulus(input int d, input logic wv, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input logic [MW-1:0] wm,
                                 input logic rv, input logic [AW-1:0] ra, input logic rr);
        wrValid    = '0;
        rdValid    = '0;
        rspReady   = '0;
        wrValid[d] = wv;
        rdValid[d] = rv;
        rspReady[d] = rr;
        wrAddr     = wa;
        wrData     = wd;
        wrMask     = wm;
        rdAddr     = ra;
        @(negedge clk);
        checkOutput(d);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int d, input logic rr);
        applyStimulus(d, 1'b0, '0, '0, '0, 1'b0, '0, rr);
    endtask

    task automatic doWrite(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v,
                           input logic [MW-1:0] m);
        applyStimulus(d, 1'b1, a, v, m, 1'b0, '0, 1'b0);
    endtask

    task automatic doRead(input int d, input logic [AW-1:0] a, input logic rr);
        applyStimulus(d, 1'b0, '0, '0, '0, 1'b1, a, rr);
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            idle(d, 1'b1);
            n++;
        end
        checkEq("drain", sb.size(), 0);
    endtask

    task automatic resetAssert(input int d);
        rstN     = 1'b0;
        wrValid  = '0;
        rdValid  = '0;
        rspReady = '0;
        #1;
        sb.delete();
        popLog.delete();
        mdlCredits = rspDepth(d);
    endtask

    task automatic resetRelease();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int accepts;
        int span;
        assertCount = 0;
        failCount   = 0;
        cyc         = 0;
        lastPopData = '0;
        lastPopErr  = 1'b0;

        for (int d = 0; d < 2; d++) begin
            $display("[TB] configuration %0d: latency %0d, queue depth %0d", d, lat(d), rspDepth(d));
            resetAssert(d);
            resetRelease();
            checkEq("resetWrReady", wrReady[d], 1'b1);
            checkEq("resetRdReady", rdReady[d], 1'b1);
            checkEq("resetRspValid", rspValid[d], 1'b0);
            checkEq("resetRspData", rspData[d], 32'h0);
            checkEq("resetRspErr", rspErr[d], 1'b0);

            // Masked write and exact read latency.
            doWrite(d, 10'd5, 32'hFFFF_FFFF, 4'b1111);
            doWrite(d, 10'd5, 32'h1234_5678, 4'b0101);
            doRead(d, 10'd5, 1'b0);
            n = 1;
            while (rspValid[d] !== 1'b1 && n < 8) begin
                idle(d, 1'b0);
                n++;
            end
            checkEq("latency", n, lat(d));
            checkEq("maskedData", rspData[d], 32'hFF34_FF78);
            checkEq("maskedErr", rspErr[d], 1'b0);
            drain(d);

            // Back-to-back reads with the consumer always ready.
            for (int i = 0; i < 8; i++) doWrite(d, AW'(i), DW'(i * 3), 4'b1111);
            popLog.delete();
            for (int i = 0; i < 8; i++) doRead(d, AW'(i), 1'b1);
            drain(d);
            checkEq("tputCount", popLog.size(), 8);
            span = (popLog.size() == 8) ? (popLog[7] - popLog[0]) : -1;
            checkEq("tputSpan", span, 7);
            checkEq("tputLast", lastPopData, 32'd21);

            // Same-address read and write on one edge.
            doWrite(d, 10'd9, 32'hAAAA_AAAA, 4'b1111);
            applyStimulus(d, 1'b1, 10'd9, 32'h5555_5555, 4'b0011, 1'b1, 10'd9, 1'b1);
            drain(d);
            checkEq("rdwData", lastPopData, (d == 0) ? 32'hAAAA_AAAA : 32'hAAAA_5555);

            // Out-of-range write is dropped, out-of-range read flags an error.
            doWrite(d, 10'd999, 32'hDEAD_BEEF, 4'b1111);
            doWrite(d, 10'd1000, 32'h0BAD_F00D, 4'b1111);
            doRead(d, 10'd1000, 1'b1);
            doRead(d, 10'd999, 1'b1);
            drain(d);
            checkEq("oorPriorData", lastPopData, 32'hDEAD_BEEF);
            checkEq("oorPriorErr", lastPopErr, 1'b0);

            // Reset with two reads outstanding discards them.
            doRead(d, 10'd1, 1'b0);
            doRead(d, 10'd2, 1'b0);
            resetAssert(d);
            checkEq("midResetRspValid", rspValid[d], 1'b0);
            checkEq("midResetRdReady", rdReady[d], 1'b1);
            checkEq("midResetRspData", rspData[d], 32'h0);
            resetRelease();
            checkEq("postResetRdReady", rdReady[d], 1'b1);
            for (int i = 0; i < 6; i++) idle(d, 1'b1);

            // Consumer stalled: credits bound the accepted reads.
            accepts = 0;
            for (int i = 0; i < rspDepth(d) + 3; i++) begin
                if (rdReady[d] === 1'b1) accepts++;
                doRead(d, AW'(i), 1'b0);
            end
            checkEq("bpAccepts", accepts, rspDepth(d));
            checkEq("bpRdReadyLow", rdReady[d], 1'b0);
            idle(d, 1'b1);
            checkEq("bpRdReadyBack", rdReady[d], 1'b1);
            drain(d);
            checkEq("bpLastData", lastPopData, DW'((rspDepth(d) - 1) * 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
